// File: rtl/csa_operand_loader.sv
// csa_operand_loader: gathers four 32-bit words into operands a and b plus carry-in and presents them to a 64-bit carry-select adder
module csa_operand_loader (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic        in_cin,
  output logic        in_ready,
  input  logic        flush,
  output logic [63:0] a,
  output logic [63:0] b,
  output logic        c_in,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [7:0]  op_count
);
  typedef enum logic [2:0] {A_LO, A_HI, B_LO, B_HI, PRESENT} state_t;
  state_t state, state_d;
  logic xfer, take;
  assign xfer = in_valid && in_ready && !flush;
  assign take = state == PRESENT && op_ready && !flush;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= A_LO;
      op_valid <= 1'b0;
      op_count <= 8'd0;
    end else begin
      state    <= state_d;
      op_valid <= state_d == PRESENT;
      op_count <= op_count + {7'd0, take};
    end
  end
  always_comb begin
    state_d = flush || take ? A_LO :
              !xfer         ? state :
              state == A_LO ? A_HI :
              state == A_HI ? B_LO :
              state == B_LO ? B_HI : PRESENT;
  end
  always_comb begin
    in_ready = state != PRESENT;
  end
  // Operand registers only move on an accepted word, so they persist past the handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a    <= 64'd0;
      b    <= 64'd0;
      c_in <= 1'b0;
    end else if (xfer) begin
      if (state == A_LO) begin
        a[31:0] <= in_data;
        c_in    <= in_cin;
      end
      if (state == A_HI) a[63:32] <= in_data;
      if (state == B_LO) b[31:0]  <= in_data;
      if (state == B_HI) b[63:32] <= in_data;
    end
  end
endmodule

// File: tb/tb_csa_operand_loader.sv
// tb_csa_operand_loader: randomized and directed checks against a word-counting reference model
module tb_csa_operand_loader;
  logic clk = 0, rst_n = 1, in_valid = 0, in_cin = 0, flush = 0, op_ready = 0;
  logic [31:0] in_data = 0;
  logic in_ready, c_in, op_valid;
  logic [63:0] a, b;
  logic [7:0] op_count;
  int checks = 0, errors = 0;
  logic [63:0] m_a, m_b;
  logic m_cin;
  logic [7:0] m_cnt;
  int m_n;
  always #5 clk = ~clk;
  csa_operand_loader dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_cin(in_cin),
    .in_ready(in_ready), .flush(flush), .a(a), .b(b), .c_in(c_in),
    .op_valid(op_valid), .op_ready(op_ready), .op_count(op_count)
  );
  task automatic model_reset;
    m_a = 0; m_b = 0; m_cin = 0; m_cnt = 0; m_n = 0;
  endtask
  // m_n counts words held in the current set; 4 means the set is on offer
  task automatic tick;
    if (flush) m_n = 0;
    else if (m_n == 4) begin
      if (op_ready) begin m_n = 0; m_cnt = m_cnt + 8'd1; end
    end else if (in_valid) begin
      if (m_n < 2) m_a[32*m_n +: 32] = in_data;
      else m_b[32*(m_n-2) +: 32] = in_data;
      if (m_n == 0) m_cin = in_cin;
      m_n++;
    end
    @(posedge clk); #1;
  endtask
  task automatic send(input logic [31:0] d, input logic c);
    in_valid = 1; in_data = d; in_cin = c;
    tick();
    in_valid = 0; in_data = $urandom; in_cin = 1'($urandom);
  endtask
  task automatic take_set;
    op_ready = 1; tick(); op_ready = 0;
  endtask
  task automatic test_reset;
    #1 rst_n = 0;
    #1 checks++;
    if ({a, b, c_in, op_valid, op_count, in_ready} !== {128'd0, 1'b0, 1'b0, 8'd0, 1'b1}) begin
      errors++; $display("FAIL reset_state got a=%h b=%h c_in=%b v=%b cnt=%0d rdy=%b", a, b, c_in, op_valid, op_count, in_ready);
    end
    model_reset();
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1 checks++;
    if (in_ready !== 1'b1 || op_valid !== 1'b0) begin errors++; $display("FAIL after_reset rdy=%b v=%b need 1/0", in_ready, op_valid); end
  endtask
  task automatic test_back_to_back;
    logic [31:0] w [4] = '{32'h1, 32'h0, 32'hFFFFFFFF, 32'h0};
    for (int i = 0; i < 4; i++) begin
      send(w[i], 1'b1);
      checks++;
      if (op_valid !== (i == 3)) begin errors++; $display("FAIL b2b_valid word %0d got %b need %b", i, op_valid, i == 3); end
    end
    checks++;
    if (a !== 64'h1 || b !== 64'hFFFFFFFF || c_in !== 1'b1) begin
      errors++; $display("FAIL b2b_operands a=%h b=%h c=%b need 1/ffffffff/1", a, b, c_in);
    end
    take_set();
    checks++;
    if (op_count !== m_cnt || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_count got %0d need %0d", op_count, m_cnt); end
  endtask
  task automatic test_stall;
    logic [31:0] w [4] = '{32'h1, 32'h0, 32'hFFFFFFFF, 32'h0};
    for (int i = 0; i < 4; i++) begin
      send(w[i], 1'b1);
      checks++;
      if (op_valid !== (i == 3)) begin errors++; $display("FAIL stall_valid word %0d got %b", i, op_valid); end
      if (i < 3) begin
        tick();
        checks++;
        if ({a, b, c_in, op_valid} !== {m_a, m_b, m_cin, 1'b0}) begin
          errors++; $display("FAIL stall_gap a=%h b=%h need %h %h", a, b, m_a, m_b);
        end
      end
    end
    checks++;
    if (a !== 64'h1 || b !== 64'hFFFFFFFF || c_in !== 1'b1) begin errors++; $display("FAIL stall_operands a=%h b=%h", a, b); end
    take_set();
  endtask
  task automatic test_hold;
    for (int i = 0; i < 4; i++) send($urandom, 1'($urandom));
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; in_data = $urandom; in_cin = 1'($urandom);
      tick();
      checks++;
      if ({a, b, c_in, op_valid, in_ready} !== {m_a, m_b, m_cin, 1'b1, 1'b0}) begin
        errors++; $display("FAIL hold cycle %0d a=%h b=%h v=%b rdy=%b need %h %h 1 0", i, a, b, op_valid, in_ready, m_a, m_b);
      end
    end
    in_valid = 0;
    take_set();
    checks++;
    if (op_count !== m_cnt || in_ready !== 1'b1 || op_valid !== 1'b0) begin
      errors++; $display("FAIL hold_release cnt=%0d rdy=%b v=%b need %0d 1 0", op_count, in_ready, op_valid, m_cnt);
    end
  endtask
  task automatic test_flush;
    logic [31:0] y;
    send($urandom, 1'b0);
    send($urandom, 1'b0);
    in_valid = 1; in_data = $urandom; flush = 1;
    tick();
    in_valid = 0; flush = 0;
    checks++;
    if ({a, b, op_count} !== {m_a, m_b, m_cnt}) begin errors++; $display("FAIL flush_discard a=%h b=%h need %h %h", a, b, m_a, m_b); end
    y = $urandom;
    send(y, 1'b1);
    checks++;
    if (a[31:0] !== y || c_in !== 1'b1 || op_count !== m_cnt) begin
      errors++; $display("FAIL flush_reload a_lo=%h c=%b cnt=%0d need %h 1 %0d", a[31:0], c_in, op_count, y, m_cnt);
    end
    for (int i = 0; i < 3; i++) send($urandom, 1'b0);
    take_set();
  endtask
  task automatic test_wrap;
    logic [7:0] start;
    start = m_cnt;
    for (int s = 0; s < 256; s++) begin
      for (int i = 0; i < 4; i++) send($urandom, 1'($urandom));
      take_set();
    end
    checks++;
    if (op_count !== start) begin errors++; $display("FAIL wrap got %0d need %0d", op_count, start); end
    for (int i = 0; i < 4; i++) send($urandom, 1'($urandom));
    op_ready = 1; flush = 1;
    tick();
    op_ready = 0; flush = 0;
    checks++;
    if (op_count !== start || op_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_vs_ready cnt=%0d v=%b need %0d 0", op_count, op_valid, start);
    end
  endtask
  task automatic test_async_reset;
    logic [31:0] d;
    send($urandom, 1'b1);
    #2 rst_n = 0;
    #1 checks++;
    if ({a, b, c_in, op_valid, op_count, in_ready} !== {128'd0, 1'b0, 1'b0, 8'd0, 1'b1}) begin
      errors++; $display("FAIL async_reset a=%h b=%h v=%b cnt=%0d", a, b, op_valid, op_count);
    end
    model_reset();
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1 checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL async_release rdy=%b need 1", in_ready); end
    d = $urandom;
    send(d, 1'b1);
    checks++;
    if (a !== {32'd0, d} || c_in !== 1'b1) begin errors++; $display("FAIL async_reload a=%h need %h", a, {32'd0, d}); end
  endtask
  task automatic test_random;
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom % 4) != 0;
      op_ready = ($urandom % 3) == 0;
      flush = ($urandom % 40) == 0;
      in_data = $urandom; in_cin = 1'($urandom);
      tick();
      checks++;
      if ({a, b, c_in, op_valid, in_ready, op_count} !== {m_a, m_b, m_cin, m_n == 4, m_n != 4, m_cnt}) begin
        errors++;
        $display("FAIL random cycle %0d a=%h b=%h c=%b v=%b rdy=%b cnt=%0d need %h %h %b %b %b %0d",
                 i, a, b, c_in, op_valid, in_ready, op_count, m_a, m_b, m_cin, m_n == 4, m_n != 4, m_cnt);
      end
    end
    in_valid = 0; op_ready = 0; flush = 0;
  endtask
  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_hold();
    test_flush();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/csa_operand_loader.md
CSA_OPERAND_LOADER -- requirements
Module: csa_operand_loader

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  upstream word valid.
REQ-005 in_data  input  32  upstream operand word.
REQ-006 in_cin  input  1  carry-in; sampled only with the first word of a set.
REQ-007 in_ready  output  1  block accepts a word this cycle.
REQ-008 flush  input  1  synchronous abort of the current set.
REQ-009 a  output  64  assembled operand A, driven to the 64-bit carry-select adder.
REQ-010 b  output  64  assembled operand B, driven to the 64-bit carry-select adder.
REQ-011 c_in  output  1  carry-in, driven to the adder.
REQ-012 op_valid  output  1  a, b and c_in form a complete, stable operand set.
REQ-013 op_ready  input  1  consumer has taken the operand set.
REQ-014 op_count  output  8  number of operand sets consumed, modulo 256.

Function
REQ-015 The FSM SHALL have the states A_LO, A_HI, B_LO, B_HI and PRESENT, encoded one-hot or binary.
REQ-016 A word transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1.
REQ-017 in_ready SHALL be 1 in states A_LO, A_HI, B_LO and B_HI, and 0 in state PRESENT.
REQ-018 On transfer in A_LO: a[31:0] <= in_data, c_in <= in_cin, and the FSM goes to A_HI.
REQ-019 On transfer in A_HI: a[63:32] <= in_data, and the FSM goes to B_LO.
REQ-020 On transfer in B_LO: b[31:0] <= in_data, and the FSM goes to B_HI.
REQ-021 On transfer in B_HI: b[63:32] <= in_data, and the FSM goes to PRESENT.
REQ-022 With no transfer, the state and all operand registers SHALL hold.
REQ-023 op_valid SHALL be registered and equal 1 exactly while in PRESENT; it rises on the cycle after the B_HI transfer.
REQ-024 In PRESENT, a, b and c_in SHALL remain constant until the op_ready handshake.
REQ-025 In PRESENT with op_ready=1: the FSM goes to A_LO and op_count increments by 1.
REQ-026 op_count SHALL wrap from 255 to 0.
REQ-027 op_ready SHALL be ignored outside PRESENT.
REQ-028 After a handshake, a, b and c_in SHALL retain their values until overwritten by the next set.
REQ-029 Minimum latency SHALL be four accepted words then one cycle to op_valid=1, so a full set with back-to-back words takes 5 cycles from the first word.
REQ-030 With flush=1, on the next edge the FSM SHALL go to A_LO from any state; operand registers and op_count hold.
REQ-031 If flush=1 coincides with a word transfer, flush SHALL win and the word is discarded.
REQ-032 If flush=1 coincides with the op_ready handshake in PRESENT, flush SHALL win and op_count does not increment.
REQ-033 Back-to-back sets SHALL be supported: a word may transfer in A_LO on the cycle after the op_ready handshake.
REQ-034 in_data and in_cin SHALL be ignored when no transfer occurs.

Reset
REQ-035 While rst_n=0, the block SHALL immediately hold state=A_LO, a=0, b=0, c_in=0, op_valid=0 and op_count=0, independent of clk.
REQ-036 After reset, in_ready SHALL be 1.
REQ-037 Reset asserted mid-set or in PRESENT SHALL discard the partial or complete set, with no op_count change beyond clearing to 0.
REQ-038 The block SHALL leave reset on the first rising clk edge after rst_n=1.

Verification
REQ-039 Back-to-back words 0x00000001, 0x00000000, 0xFFFFFFFF, 0x00000000 with in_cin=1 -> op_valid=1 on cycle 5, a=0x1, b=0xFFFFFFFF, c_in=1.
REQ-040 Stall test: in_valid toggles 1/0 with the same 4 words -> same a/b; op_valid rises 1 cycle after the 4th transfer; the registers hold during gaps.
REQ-041 Hold test: op_ready=0 for 10 cycles in PRESENT -> a, b, c_in and op_valid are stable and in_ready=0; then op_ready=1 -> op_count increments by 1 and the FSM is in A_LO next cycle.
REQ-042 flush asserted in B_LO together with a valid word -> the word is discarded, the next word loads a[31:0], and op_count is unchanged.
REQ-043 Run 256 complete sets -> op_count returns to 0; flush coinciding with op_ready -> no increment.
REQ-044 rst_n pulsed low asynchronously in A_HI -> all outputs are 0 immediately, in_ready=1 after release, and the next word loads a[31:0].
